// File: rtl/lockeddoor_pkg.sv
// Shared keypad codes, sequencer state encoding and key classification helpers.
package lockeddoor_pkg;

  localparam int KEY_W = 12;

  localparam logic [KEY_W-1:0] CHR_0 = 12'h001;
  localparam logic [KEY_W-1:0] CHR_1 = 12'h002;
  localparam logic [KEY_W-1:0] CHR_2 = 12'h004;
  localparam logic [KEY_W-1:0] CHR_3 = 12'h008;
  localparam logic [KEY_W-1:0] CHR_4 = 12'h010;
  localparam logic [KEY_W-1:0] CHR_5 = 12'h020;
  localparam logic [KEY_W-1:0] CHR_6 = 12'h040;
  localparam logic [KEY_W-1:0] CHR_7 = 12'h080;
  localparam logic [KEY_W-1:0] CHR_8 = 12'h100;
  localparam logic [KEY_W-1:0] CHR_9 = 12'h200;
  localparam logic [KEY_W-1:0] CHR_s = 12'h400;
  localparam logic [KEY_W-1:0] CHR_p = 12'h800;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    VERIFY  = 3'd2,
    CHANGE  = 3'd3,
    UNLOCK  = 3'd4,
    LOCKOUT = 3'd5
  } state_e;

  function automatic logic is_onehot(input logic [KEY_W-1:0] k);
    return (k != '0) && ((k & (k - 12'd1)) == '0);
  endfunction

  function automatic logic is_digit(input logic [KEY_W-1:0] k);
    return is_onehot(k) && (k[9:0] != '0);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Keypad validity check, press-event pulse and registered gated code toward lockeddoor.
module key_edge_detect
  import lockeddoor_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_i,
  input  logic             gate_en_i,
  output logic             press_o,
  output logic [KEY_W-1:0] key_o
);

  logic             key_vld;
  logic [KEY_W-1:0] key_prev_q;
  logic [KEY_W-1:0] key_out_q;

  assign key_vld = is_onehot(key_i);
  // Invalid codes are remembered as "no key" so they never block or fake a press.
  assign press_o = key_vld && (key_prev_q == '0);
  assign key_o   = key_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev_q <= '0;
      key_out_q  <= '0;
    end else begin
      key_prev_q <= key_vld ? key_i : '0;
      key_out_q  <= (key_vld && gate_en_i) ? key_i : '0;
    end
  end

endmodule

// File: rtl/keypad_access_ctrl.sv
// Keypad-to-lockeddoor sequencer: code-entry tracking, verify window, relay hold
// timer, failure counting and timed lockout.
module keypad_access_ctrl
  import lockeddoor_pkg::*;
#(
  parameter int CODE_LEN    = 6,
  parameter int VERIFY_WAIT = 16,
  parameter int DOOR_HOLD   = 40,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 200,
  localparam int FAIL_W     = $clog2(MAX_FAIL + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              door_open_in,
  output logic [KEY_W-1:0]  key_out,
  output logic              relay_on,
  output logic              locked_out,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic [2:0]        state_o
);

  localparam int TMR_MAX = (VERIFY_WAIT > DOOR_HOLD)
                         ? ((VERIFY_WAIT > LOCK_CYCLES) ? VERIFY_WAIT : LOCK_CYCLES)
                         : ((DOOR_HOLD > LOCK_CYCLES) ? DOOR_HOLD : LOCK_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int CNT_W   = $clog2(2 * CODE_LEN + 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   digit_q, digit_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic               relay_q, locked_q;
  logic               press, gate_en;
  logic               dig_ev, star_ev, hash_ev;
  logic [CNT_W-1:0]   digit_inc;
  logic [FAIL_W-1:0]  fail_inc;

  assign gate_en = (state_q == IDLE) || (state_q == ENTRY) || (state_q == CHANGE);

  key_edge_detect u_key_edge (
    .clk       (clk),
    .reset     (reset),
    .key_i     (key_in),
    .gate_en_i (gate_en),
    .press_o   (press),
    .key_o     (key_out)
  );

  assign dig_ev    = press && is_digit(key_in);
  assign star_ev   = press && (key_in == CHR_s);
  assign hash_ev   = press && (key_in == CHR_p);
  assign digit_inc = digit_q + CNT_W'(1);
  assign fail_inc  = (fail_q == FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + FAIL_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    digit_d = digit_q;
    fail_d  = fail_q;
    // An open report ends any attempt in progress, and beats a same-cycle timeout.
    if (door_open_in && ((state_q == IDLE) || (state_q == ENTRY) || (state_q == VERIFY))) begin
      state_d = UNLOCK;
      timer_d = TMR_W'(DOOR_HOLD - 1);
      digit_d = '0;
      fail_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dig_ev) begin
            state_d = ENTRY;
            digit_d = CNT_W'(1);
          end else if (star_ev) begin
            state_d = CHANGE;
            digit_d = '0;
          end
        end
        ENTRY: begin
          if (hash_ev) begin
            state_d = IDLE;
            digit_d = '0;
          end else if (dig_ev) begin
            digit_d = digit_inc;
            if (digit_inc == CNT_W'(CODE_LEN)) begin
              state_d = VERIFY;
              timer_d = TMR_W'(VERIFY_WAIT - 1);
            end
          end
        end
        VERIFY: begin
          if (timer_q == '0) begin
            fail_d  = fail_inc;
            digit_d = '0;
            if (fail_inc == FAIL_W'(MAX_FAIL)) begin
              state_d = LOCKOUT;
              timer_d = TMR_W'(LOCK_CYCLES - 1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        CHANGE: begin
          if (hash_ev) begin
            state_d = IDLE;
            digit_d = '0;
          end else if (dig_ev) begin
            digit_d = digit_inc;
            if (digit_inc == CNT_W'(2 * CODE_LEN)) begin
              state_d = IDLE;
              digit_d = '0;
            end
          end
        end
        UNLOCK: begin
          if (door_open_in) begin
            timer_d = TMR_W'(DOOR_HOLD - 1);
          end else if (timer_q == '0) begin
            state_d = IDLE;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        LOCKOUT: begin
          if (timer_q == '0) begin
            state_d = IDLE;
            fail_d  = '0;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
          digit_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      digit_q  <= '0;
      fail_q   <= '0;
      relay_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      digit_q  <= digit_d;
      fail_q   <= fail_d;
      relay_q  <= (state_d == UNLOCK);
      locked_q <= (state_d == LOCKOUT);
    end
  end

  assign relay_on   = relay_q;
  assign locked_out = locked_q;
  assign fail_cnt   = fail_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_keypad_access_ctrl.sv
// Directed scenarios plus randomized key/open traffic checked against a behavioural model.
module tb_keypad_access_ctrl;
  import lockeddoor_pkg::*;

  localparam int CODE_LEN = 6, VERIFY_WAIT = 16, DOOR_HOLD = 40, MAX_FAIL = 3, LOCK_CYCLES = 200;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_VERIFY = 2, M_CHANGE = 3, M_UNLOCK = 4, M_LOCKOUT = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] key_in = '0;
  logic        door_open_in = 1'b0;
  logic [11:0] key_out;
  logic        relay_on, locked_out;
  logic [1:0]  fail_cnt;
  logic [2:0]  state_o;

  keypad_access_ctrl dut (
    .clk(clk), .reset(reset), .key_in(key_in), .door_open_in(door_open_in),
    .key_out(key_out), .relay_on(relay_on), .locked_out(locked_out),
    .fail_cnt(fail_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit cmp_en = 0, rand_open = 0;
  int relay_cycles = 0, lock_cycles = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: plain integers stepping through the documented rules.
  int          m_mode = 0, m_cnt = 0, m_tmr = 0, m_fail = 0;
  logic [11:0] m_prev = '0, m_key_out = '0;
  bit          m_relay = 0, m_lock = 0;
  bit          mv, mev, mdig, mstar, mhash;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_cnt = 0; m_tmr = 0; m_fail = 0;
      m_prev = '0; m_key_out = '0; m_relay = 0; m_lock = 0;
    end else begin
      mv    = ($countones(key_in) == 1);
      mev   = mv && (m_prev == 0);
      m_prev = mv ? key_in : 12'h000;
      m_key_out = (mv && (m_mode == M_IDLE || m_mode == M_ENTRY || m_mode == M_CHANGE)) ? key_in : 12'h000;
      mdig  = mev && (key_in[9:0] != 0);
      mstar = mev && (key_in == CHR_s);
      mhash = mev && (key_in == CHR_p);
      if (door_open_in && (m_mode == M_IDLE || m_mode == M_ENTRY || m_mode == M_VERIFY)) begin
        m_mode = M_UNLOCK; m_tmr = DOOR_HOLD - 1; m_fail = 0; m_cnt = 0;
      end else begin
        case (m_mode)
          M_IDLE:
            if (mdig) begin m_mode = M_ENTRY; m_cnt = 1; end
            else if (mstar) begin m_mode = M_CHANGE; m_cnt = 0; end
          M_ENTRY:
            if (mhash) begin m_mode = M_IDLE; m_cnt = 0; end
            else if (mdig) begin
              m_cnt++;
              if (m_cnt == CODE_LEN) begin m_mode = M_VERIFY; m_tmr = VERIFY_WAIT - 1; end
            end
          M_VERIFY:
            if (m_tmr == 0) begin
              m_fail = (m_fail + 1 > MAX_FAIL) ? MAX_FAIL : m_fail + 1;
              m_cnt = 0;
              if (m_fail == MAX_FAIL) begin m_mode = M_LOCKOUT; m_tmr = LOCK_CYCLES - 1; end
              else m_mode = M_IDLE;
            end else m_tmr--;
          M_CHANGE:
            if (mhash) begin m_mode = M_IDLE; m_cnt = 0; end
            else if (mdig) begin
              m_cnt++;
              if (m_cnt == 2 * CODE_LEN) begin m_mode = M_IDLE; m_cnt = 0; end
            end
          M_UNLOCK:
            if (door_open_in) m_tmr = DOOR_HOLD - 1;
            else if (m_tmr == 0) m_mode = M_IDLE;
            else m_tmr--;
          M_LOCKOUT:
            if (m_tmr == 0) begin m_mode = M_IDLE; m_fail = 0; end
            else m_tmr--;
          default: m_mode = M_IDLE;
        endcase
      end
      m_relay = (m_mode == M_UNLOCK);
      m_lock  = (m_mode == M_LOCKOUT);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("key_out", int'(key_out), int'(m_key_out));
      chk("relay_on", int'(relay_on), int'(m_relay));
      chk("locked_out", int'(locked_out), int'(m_lock));
      chk("fail_cnt", int'(fail_cnt), m_fail);
      chk("state_o", int'(state_o), m_mode);
    end
    if (relay_on) relay_cycles++;
    if (locked_out) lock_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_open) door_open_in = ($urandom_range(0, 39) == 0);
  endtask

  task automatic press(input logic [11:0] k, input int hold, input int gap);
    key_in = k;
    repeat (hold) tick();
    key_in = '0;
    repeat (gap) tick();
  endtask

  task automatic wait_state(input int exp, input int budget, input string name);
    int n = 0;
    while (int'(state_o) != exp && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(state_o), exp);
  endtask

  function automatic logic [11:0] digit_key(input int d);
    logic [11:0] one = 12'd1;
    return one << d;
  endfunction

  initial begin
    logic [11:0] k;
    int r, a, b;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_key_out", int'(key_out), 0);
    chk("rst_relay", int'(relay_on), 0);
    chk("rst_locked", int'(locked_out), 0);
    chk("rst_fail", int'(fail_cnt), 0);
    chk("rst_state", int'(state_o), M_IDLE);
    reset = 1'b0;
    cmp_en = 1;
    tick();

    // Code 1..6, open pulse in the third VERIFY cycle.
    relay_cycles = 0;
    key_in = CHR_1;
    tick();
    chk("s1_key_mirror", int'(key_out), int'(CHR_1));
    chk("s1_entry", int'(state_o), M_ENTRY);
    repeat (9) tick();
    key_in = '0;
    repeat (10) tick();
    for (int d = 2; d <= 5; d++) press(digit_key(d), 10, 10);
    key_in = CHR_6;
    tick();
    chk("s1_verify", int'(state_o), M_VERIFY);
    tick();
    tick();
    door_open_in = 1'b1;
    tick();
    door_open_in = 1'b0;
    chk("s1_unlock", int'(state_o), M_UNLOCK);
    chk("s1_relay_on", int'(relay_on), 1);
    repeat (6) tick();
    key_in = '0;
    wait_state(M_IDLE, 100, "s1_back_idle");
    chk("s1_relay_cycles", relay_cycles, DOOR_HOLD);
    chk("s1_fail", int'(fail_cnt), 0);

    // '#' abort, then a full fresh entry is needed.
    press(CHR_1, 3, 3);
    press(CHR_2, 3, 3);
    chk("s2_entry", int'(state_o), M_ENTRY);
    press(CHR_p, 3, 3);
    chk("s2_hash_idle", int'(state_o), M_IDLE);
    for (int d = 3; d <= 7; d++) press(digit_key(d), 2, 2);
    chk("s2_five_digits", int'(state_o), M_ENTRY);
    press(CHR_9, 1, 0);
    chk("s2_sixth_verify", int'(state_o), M_VERIFY);
    tick();
    door_open_in = 1'b1;
    tick();
    door_open_in = 1'b0;
    chk("s2_unlock", int'(state_o), M_UNLOCK);
    wait_state(M_IDLE, 100, "s2_back_idle");

    // Three failed attempts -> lockout.
    for (int at = 1; at <= MAX_FAIL; at++) begin
      if (at == MAX_FAIL) lock_cycles = 0;
      for (int d = 0; d < CODE_LEN; d++) press(digit_key(d), 2, 2);
      wait_state((at < MAX_FAIL) ? M_IDLE : M_LOCKOUT, 40, "s3_after_attempt");
      chk("s3_fail_step", int'(fail_cnt), at);
    end
    chk("s3_locked_out", int'(locked_out), 1);
    key_in = CHR_5;
    tick();
    chk("s3_lock_key_gate", int'(key_out), 0);
    key_in = '0;
    wait_state(M_IDLE, 250, "s3_lock_expire");
    chk("s3_lock_cycles", lock_cycles, LOCK_CYCLES);
    chk("s3_fail_clear", int'(fail_cnt), 0);

    // Code change: fail_cnt is left untouched.
    for (int d = 0; d < CODE_LEN; d++) press(digit_key(9 - d), 2, 2);
    wait_state(M_IDLE, 40, "s4_fail_attempt");
    chk("s4_fail_one", int'(fail_cnt), 1);
    press(CHR_s, 2, 2);
    chk("s4_change", int'(state_o), M_CHANGE);
    for (int d = 0; d < 2 * CODE_LEN - 1; d++) press(digit_key($urandom_range(0, 9)), 2, 2);
    chk("s4_still_change", int'(state_o), M_CHANGE);
    press(CHR_4, 2, 2);
    chk("s4_change_done", int'(state_o), M_IDLE);
    chk("s4_fail_kept", int'(fail_cnt), 1);

    // Multi-bit code is no key; a long hold is a single press.
    key_in = 12'h003;
    repeat (5) tick();
    chk("s5_multibit_key_out", int'(key_out), 0);
    chk("s5_multibit_idle", int'(state_o), M_IDLE);
    key_in = '0;
    tick();
    tick();
    key_in = CHR_7;
    repeat (30) tick();
    chk("s5_single_event", int'(state_o), M_ENTRY);
    key_in = '0;
    tick();
    for (int d = 0; d < CODE_LEN - 2; d++) press(digit_key(d), 2, 2);
    chk("s5_five_counted", int'(state_o), M_ENTRY);
    press(CHR_8, 2, 2);
    chk("s5_verify", int'(state_o), M_VERIFY);
    door_open_in = 1'b1;
    tick();
    door_open_in = 1'b0;
    chk("s5_unlock", int'(state_o), M_UNLOCK);

    // Asynchronous reset in the middle of the relay hold.
    repeat (19) tick();
    chk("s6_relay_before", int'(relay_on), 1);
    reset = 1'b1;
    #1;
    chk("s6_relay_drop", int'(relay_on), 0);
    chk("s6_state_idle", int'(state_o), M_IDLE);
    chk("s6_fail_zero", int'(fail_cnt), 0);
    chk("s6_key_out_zero", int'(key_out), 0);
    tick();
    reset = 1'b0;
    tick();

    // Randomized traffic with sporadic open pulses.
    rand_open = 1;
    repeat (120) begin
      r = $urandom_range(0, 15);
      if (r < 12) k = digit_key(r);
      else if (r < 14) k = digit_key($urandom_range(0, 9));
      else begin
        a = $urandom_range(0, 11);
        b = (a + 1 + $urandom_range(0, 10)) % 12;
        k = digit_key(a) | digit_key(b);
      end
      press(k, $urandom_range(1, 6), $urandom_range(1, 4));
    end
    rand_open = 0;
    door_open_in = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_access_ctrl.md
Name: keypad_access_ctrl

Overview:
- Sequencer between the 12-key one-hot keypad and the lockeddoor password block.
- Gates and registers keypad codes into lockeddoor and tracks code-entry progress.
- Watches lockeddoor's open output, drives the door relay with a hold timer, and counts failed attempts.
- Enforces a timed lockout after repeated failures; fully synchronous to clk.

Parameters:
- CODE_LEN, 6, digits per code.
- VERIFY_WAIT, 16, cycles allowed for door_open_in after the last digit.
- DOOR_HOLD, 40, relay-on cycles per unlock.
- MAX_FAIL, 3, consecutive failures that trigger lockout.
- LOCK_CYCLES, 200, lockout duration in cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_in  in  12  raw keypad code: bits 0-9 are digits 0-9, bit 10 is '*', bit 11 is '#'.
- door_open_in  in  1  open output of lockeddoor.
- key_out  out  12  gated and registered code to lockeddoor inputChar.
- relay_on  out  1  door relay drive.
- locked_out  out  1  high during lockout.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failure count.
- state_o  out  3  current FSM state, for debug.

Behaviour:
- Reset values: key_out=0, relay_on=0, locked_out=0, fail_cnt=0, state=IDLE, internal timer=0, digit_cnt=0, key_prev=0.
- Valid key: key_in has exactly one bit set. Zero or multi-bit values are treated as "no key".
- Press event: valid key this cycle while key_prev==0, with key_prev registered every cycle. A key held for N cycles gives one event.
- Pass-through: in IDLE, ENTRY and CHANGE, key_out <= valid ? key_in : 0 (1-cycle latency). In all other states key_out <= 0.
- IDLE:
  - Digit event: go to ENTRY, digit_cnt=1.
  - '*' event: go to CHANGE, digit_cnt=0.
  - '#' event: ignored.
- ENTRY:
  - Digit event: digit_cnt++.
  - When digit_cnt reaches CODE_LEN: go to VERIFY, timer=VERIFY_WAIT-1.
  - '#': go to IDLE, digit_cnt=0.
  - '*': ignored for counting.
- VERIFY:
  - door_open_in=1: go to UNLOCK, timer=DOOR_HOLD-1, fail_cnt=0.
  - timer==0 without open: fail_cnt++. If the new value equals MAX_FAIL, go to LOCKOUT with timer=LOCK_CYCLES-1; otherwise go to IDLE. digit_cnt=0 in both cases.
  - Otherwise: timer--.
  - If open and timeout occur in the same cycle, open wins.
- CHANGE:
  - Digit events are counted; no failure counting in this state.
  - At 2*CODE_LEN digits (old code then new code): go to IDLE.
  - '#': go to IDLE.
  - door_open_in is ignored.
- Early open: door_open_in=1 in IDLE or ENTRY goes to UNLOCK exactly as in VERIFY.
- UNLOCK:
  - relay_on=1 (registered, asserted from the cycle the state is entered).
  - timer-- each cycle; at 0 go to IDLE.
  - door_open_in=1 reloads timer=DOOR_HOLD-1.
- LOCKOUT:
  - locked_out=1 and key_out=0; door_open_in is ignored.
  - At timer==0: go to IDLE, fail_cnt=0.
- fail_cnt saturates at MAX_FAIL and is cleared only by an unlock, lockout expiry or reset.
- Timer width is $clog2 of the largest of VERIFY_WAIT, DOOR_HOLD and LOCK_CYCLES. Counters never wrap.
- Reset mid-operation: all outputs drop to their reset values in the same cycle (asynchronous). An attempt in progress is discarded.

Decomposition:
- Shared package (lockeddoor_pkg):
  - key one-hot constants CHR_0..CHR_9, CHR_s, CHR_p.
  - state enum: IDLE, ENTRY, VERIFY, CHANGE, UNLOCK, LOCKOUT (3-bit encoding).
  - is_digit and is_onehot functions.
- Sub-module key_edge_detect: validity check plus press-event pulse and registered gate. Everything else lives in a single FSM/timer block.

Test Plan:
- After reset: press CHR_1 through CHR_6, each held 10 cycles with 10-cycle gaps, and drive door_open_in=1 for 1 cycle at the 3rd VERIFY cycle -> key_out mirrors each key 1 cycle late; relay_on=1 for exactly 40 cycles; fail_cnt=0; return to IDLE.
- Press 1, 2, # -> state goes IDLE->ENTRY->IDLE, digit_cnt=0; a following 6-digit entry needs 6 fresh digits before VERIFY.
- Three 6-digit entries with door_open_in held 0 -> fail_cnt steps 1, 2, 3; locked_out=1 for 200 cycles; key_out=0 throughout even with keys pressed; then IDLE with fail_cnt=0.
- Press '*' then 12 digits with no open -> stays in CHANGE until the 12th digit, then IDLE; fail_cnt unchanged.
- Multi-bit key_in 12'h003 held, then one key held 30 cycles -> the multi-bit value produces no event and key_out=0; the held key produces one event and digit_cnt+1.
- Assert reset during UNLOCK at cycle 20 -> relay_on=0 immediately; state=IDLE; all counters 0.
